// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage branch hazard controller.
//   - Forwarding select encodings for the ID branch comparator operand muxes.
//   - FSM state type (RUN / STALL).
//   - Helpers that turn per-operand hazard matches into a stall requirement.
package branch_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from MEM/WB write data

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Bubbles needed before one branch operand is available to the comparator.
  // A load in EX needs two cycles to reach MEM/WB; an ALU op in EX needs one
  // to reach EX/MEM; a load in MEM needs one to reach MEM/WB.
  function automatic logic [1:0] operand_need(input logic ex_match,
                                              input logic ex_load,
                                              input logic mem_match,
                                              input logic mem_load);
    logic [1:0] n;
    if (ex_match)
      n = ex_load ? 2'd2 : 2'd1;
    else if (mem_match && mem_load)
      n = 2'd1;
    else
      n = 2'd0;
    return n;
  endfunction

  function automatic logic [1:0] need_max(input logic [1:0] a,
                                          input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the branch performance statistics.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset, clears the count
//   i_en in   increment request (at most one step per cycle)
//   o_q  out  current count; sticks at all-ones and never wraps
module branch_hazard_ctrl_sat_counter
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_q
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)
      r_q <= '0;
    else if (i_en && (r_q != '1))
      r_q <= r_q + ONE;
  end

  assign o_q = r_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Early branch resolution control for the ID stage.
// Detects RAW hazards between the branch source registers in ID and the
// destinations in ID/EX and EX/MEM, stalls IF/ID for the needed number of
// cycles, drives the comparator forwarding selects, and flushes IF/ID when
// a resolved branch is taken. Also keeps saturating statistics counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_hold                        global freeze; outputs idle, state held
//   i_id_is_branch                branch valid in ID
//   i_id_rs1, i_id_rs2            branch source registers
//   i_branch_taken                comparator result (with forwarded operands)
//   i_ex_rd/_reg_write/_mem_read  ID/EX destination info
//   i_mem_rd/_reg_write/_mem_read EX/MEM destination info
//   i_wb_rd/_reg_write            MEM/WB destination info
//   o_pc_write, o_ifid_write      PC / IF/ID load enables
//   o_ifid_flush                  IF/ID loads a NOP
//   o_idex_bubble                 ID/EX control fields zeroed
//   o_fwd_a_sel, o_fwd_b_sel      comparator operand source selects
//   o_cnt_branch/_taken/_stall    statistics counters
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hold,
  input  logic             i_id_is_branch,
  input  logic [RA_W-1:0]  i_id_rs1,
  input  logic [RA_W-1:0]  i_id_rs2,
  input  logic             i_branch_taken,
  input  logic [RA_W-1:0]  i_ex_rd,
  input  logic             i_ex_reg_write,
  input  logic             i_ex_mem_read,
  input  logic [RA_W-1:0]  i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic             i_mem_mem_read,
  input  logic [RA_W-1:0]  i_wb_rd,
  input  logic             i_wb_reg_write,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic [CNT_W-1:0] o_cnt_branch,
  output logic [CNT_W-1:0] o_cnt_taken,
  output logic [CNT_W-1:0] o_cnt_stall
);

  state_t     r_state, w_state_nxt;
  // Number of further STALL cycles after the current one.
  logic [1:0] r_stall_cnt, w_stall_cnt_nxt;

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;
  logic [1:0] w_need;
  logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble, w_resolve;

  // x0 is hardwired zero, so it never creates a dependency.
  assign w_ex_m1  = i_ex_reg_write  && (i_ex_rd  != '0) && (i_ex_rd  == i_id_rs1);
  assign w_ex_m2  = i_ex_reg_write  && (i_ex_rd  != '0) && (i_ex_rd  == i_id_rs2);
  assign w_mem_m1 = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_id_rs1);
  assign w_mem_m2 = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_id_rs2);
  assign w_wb_m1  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_id_rs1);
  assign w_wb_m2  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_id_rs2);

  assign w_need = i_id_is_branch ?
                  need_max(operand_need(w_ex_m1, i_ex_mem_read, w_mem_m1, i_mem_mem_read),
                           operand_need(w_ex_m2, i_ex_mem_read, w_mem_m2, i_mem_mem_read)) :
                  2'd0;

  // A load result in EX/MEM is not yet available, so it cannot be forwarded;
  // MEM/WB then supplies it once the stall has moved it along.
  always_comb begin
    o_fwd_a_sel = FWD_RF;
    o_fwd_b_sel = FWD_RF;
    if (w_mem_m1 && !i_mem_mem_read)
      o_fwd_a_sel = FWD_EXMEM;
    else if (w_wb_m1)
      o_fwd_a_sel = FWD_MEMWB;
    if (w_mem_m2 && !i_mem_mem_read)
      o_fwd_b_sel = FWD_EXMEM;
    else if (w_wb_m2)
      o_fwd_b_sel = FWD_MEMWB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // The RUN cycle that detects the hazard is itself the first bubble, so
  // STALL is entered only when more than one bubble is required and holds
  // for need-1 cycles.
  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_pc_write      = 1'b1;
    w_ifid_write    = 1'b1;
    w_ifid_flush    = 1'b0;
    w_idex_bubble   = 1'b0;
    w_resolve       = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_need != 2'd0) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          if (w_need > 2'd1) begin
            w_state_nxt     = ST_STALL;
            w_stall_cnt_nxt = w_need - 2'd2;
          end
        end else if (i_id_is_branch) begin
          w_resolve    = 1'b1;
          w_ifid_flush = i_branch_taken;
        end
      end
      ST_STALL: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
        if (r_stall_cnt == 2'd0)
          w_state_nxt = ST_RUN;
        else
          w_stall_cnt_nxt = r_stall_cnt - 2'd1;
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_stall_cnt_nxt = 2'd0;
      end
    endcase

    // Freeze: nothing advances and nothing is counted.
    if (i_hold) begin
      w_pc_write      = 1'b0;
      w_ifid_write    = 1'b0;
      w_ifid_flush    = 1'b0;
      w_idex_bubble   = 1'b0;
      w_resolve       = 1'b0;
      w_state_nxt     = r_state;
      w_stall_cnt_nxt = r_stall_cnt;
    end
  end

  assign o_pc_write    = w_pc_write;
  assign o_ifid_write  = w_ifid_write;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_idex_bubble = w_idex_bubble;

  branch_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_branch (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_resolve),
    .o_q  (o_cnt_branch)
  );

  branch_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_resolve && i_branch_taken),
    .o_q  (o_cnt_taken)
  );

  branch_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_idex_bubble),
    .o_q  (o_cnt_stall)
  );

endmodule
